mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 32: maximum cycles in BUSY before a timeout error; legal range 2..63.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 memReadIn  input  1  current MEM-stage instruction is a load.
REQ-005 memWriteIn  input  1  current MEM-stage instruction is a store.
REQ-006 addrIn  input  16  byte address from ALU output.
REQ-007 wrDataIn  input  16  store data.
REQ-008 memDone  input  1  memory completed the request this cycle; may be set in the issue cycle (hit).
REQ-009 memRdData  input  16  memory read data; valid only while memDone=1.
REQ-010 memErrIn  input  1  memory-reported error.
REQ-011 memEn  output  1  one-cycle request strobe to data memory.
REQ-012 memWr  output  1  write qualifier for memEn.
REQ-013 memAddr, memWrData  output  16 each  address and store data, driven with memEn.
REQ-014 stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM write enables.
REQ-015 wbBubble  output  1  forces a NOP (zero control word) into MEM/WB this cycle.
REQ-016 loadData  output  16  data to MEM/WB DMemData input.
REQ-017 err  output  1  sticky error flag.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-019 In IDLE with exactly one of memReadIn/memWriteIn set, memEn SHALL be 1 and memWr SHALL equal memWriteIn, with memAddr/memWrData driven combinationally from addrIn/wrDataIn.
REQ-020 An issue in IDLE with memDone=1 in the same cycle SHALL cause no stall: loadData=memRdData for that cycle and the FSM stays in IDLE.
REQ-021 An issue in IDLE with memDone=0 SHALL transition to BUSY and latch addrIn/wrDataIn/memWr.
REQ-022 In BUSY: memEn=0, stall=1, wbBubble=1, the latched address/data stay driven, and the timeout counter increments each cycle.
REQ-023 In BUSY with memDone=1: capture memRdData into the load-data register and transition to RESP.
REQ-024 In RESP: stall=0, wbBubble=0, loadData=captured value, memEn=0; the next state SHALL be IDLE unconditionally, so a request presented during RESP is issued in the following IDLE cycle.
REQ-025 In IDLE with no request: stall=0, wbBubble=0, memEn=0, loadData=16'h0000.
REQ-026 memReadIn and memWriteIn both set in IDLE SHALL cause no issue, set err, and leave the state at IDLE.
REQ-027 memErrIn=1 in any state SHALL set err; the FSM otherwise proceeds normally.
REQ-028 err SHALL stay set until rst.
REQ-029 The counter SHALL be 6 bits and zero on entry to BUSY.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, clear the counter, the load-data register and err, with all outputs 0 the following cycle.
REQ-031 rst SHALL take effect even in BUSY; an in-flight request is abandoned and a late memDone in IDLE without a request is ignored.
REQ-032 While rst=1, err SHALL read 0.

Configuration
REQ-033 With MEM_STAGE_CTRL_TIMEOUT_EN defined: reaching count TIMEOUT-1 in BUSY without memDone SHALL set err and transition to IDLE, with stall=0 from the next cycle.
REQ-034 Without MEM_STAGE_CTRL_TIMEOUT_EN: no counter logic is generated and BUSY waits indefinitely.

Structure
REQ-035 A shared package SHALL hold the state encodings (IDLE=2'b00, BUSY=2'b01, RESP=2'b10) and the default TIMEOUT constant.
REQ-036 The load-data capture SHALL instantiate the existing 16-bit register sub-module, with writeEn = (BUSY & memDone); its err output is ORed into err.

Verification
REQ-037 Hit: load, addrIn=16'h0040, memDone=1 with memRdData=16'hBEEF in the issue cycle -> memEn=1 for 1 cycle, stall never asserts, loadData=16'hBEEF that cycle.
REQ-038 Miss: store to 16'h0100, memDone arrives 4 cycles after issue -> stall=1 and wbBubble=1 for 4 cycles, one RESP cycle, memEn pulses exactly once.
REQ-039 Load miss: memDone with memRdData=16'h1234 after 2 BUSY cycles -> loadData=16'h1234 during RESP; an immediate following load issues in the next IDLE cycle.
REQ-040 Conflict: memReadIn=memWriteIn=1 -> memEn=0, err=1 and stays 1 until rst.
REQ-041 Reset mid-BUSY: rst pulsed in BUSY cycle 2 -> IDLE with all outputs 0 next cycle; a subsequent memDone causes no output change.
REQ-042 With MEM_STAGE_CTRL_TIMEOUT_EN and TIMEOUT=8, memDone never asserted -> err set after 8 BUSY cycles, then IDLE with stall=0.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl_pkg
// Shared definitions for the MEM-stage memory controller slice:
//   - state_e          : controller FSM encoding (IDLE / BUSY / RESP)
//   - TIMEOUT_DEFAULT  : default BUSY timeout in cycles
//   - parity16()       : even-parity helper used by the load-data register
// ----------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int TIMEOUT_DEFAULT = 32;

  function automatic logic parity16(input logic [15:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_reg.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl_reg
// 16-bit data register with a stored parity bit. The parity is recomputed on
// every read and compared against the stored bit, so a corrupted word shows
// up on err.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, clears data and parity
//   writeEn  in   load dataIn on the next rising edge
//   dataIn   in   16-bit write data
//   dataOut  out  16-bit stored data
//   err      out  stored parity does not match stored data
// ----------------------------------------------------------------------------
module mem_stage_ctrl_reg
  import mem_stage_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        writeEn,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut,
  output logic        err
);

  logic [15:0] data_q, data_d;
  logic        parity_q, parity_d;

  always_comb begin
    data_d   = data_q;
    parity_d = parity_q;
    if (writeEn) begin
      data_d   = dataIn;
      parity_d = parity16(dataIn);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      parity_q <= parity_d;
    end
  end

  assign dataOut = data_q;
  assign err     = parity16(data_q) != parity_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage data-memory controller. Issues a one-cycle request strobe for a
// load or store, stalls the upstream pipeline while the memory is busy,
// inserts bubbles into MEM/WB during the stall and presents the load data
// for one RESP cycle once the memory answers. Same-cycle completions (hits)
// never stall.
//
// Optional feature: define MEM_STAGE_CTRL_TIMEOUT_EN to add a 6-bit BUSY
// timeout counter; when it reaches TIMEOUT-1 without memDone the request is
// dropped, err is set and the FSM returns to IDLE. Without the macro BUSY
// waits indefinitely and no counter exists.
//
// Parameters:
//   TIMEOUT     maximum BUSY cycles before timeout (2..63)
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   memReadIn   in   MEM-stage instruction is a load
//   memWriteIn  in   MEM-stage instruction is a store
//   addrIn      in   16-bit byte address from the ALU
//   wrDataIn    in   16-bit store data
//   memDone     in   memory completed the request this cycle
//   memRdData   in   16-bit memory read data, valid with memDone
//   memErrIn    in   memory-reported error
//   memEn       out  one-cycle request strobe
//   memWr       out  write qualifier for memEn
//   memAddr     out  16-bit request address
//   memWrData   out  16-bit request store data
//   stall       out  freeze PC, IF/ID, ID/EX and EX/MEM
//   wbBubble    out  force a NOP into MEM/WB
//   loadData    out  16-bit data for the MEM/WB DMemData input
//   err         out  sticky error flag (reads 0 while rst is high)
// ----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic [15:0] addrIn,
  input  logic [15:0] wrDataIn,
  input  logic        memDone,
  input  logic [15:0] memRdData,
  input  logic        memErrIn,
  output logic        memEn,
  output logic        memWr,
  output logic [15:0] memAddr,
  output logic [15:0] memWrData,
  output logic        stall,
  output logic        wbBubble,
  output logic [15:0] loadData,
  output logic        err
);

  if (TIMEOUT < 2 || TIMEOUT > 63) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT must be in 2..63");
  end

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;

  logic        req_one;
  logic        req_conflict;
  logic        load_we;
  logic [15:0] load_q;
  logic        load_reg_err;

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
  localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);
  logic [5:0] cnt_q, cnt_d;
`endif

  assign req_one      = memReadIn ^ memWriteIn;
  assign req_conflict = memReadIn & memWriteIn;

  // Capture read data only on a BUSY completion; hits bypass the register.
  assign load_we = (state_q == BUSY) && memDone;

  mem_stage_ctrl_reg u_load_reg (
    .clk     (clk),
    .rst     (rst),
    .writeEn (load_we),
    .dataIn  (memRdData),
    .dataOut (load_q),
    .err     (load_reg_err)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    err_d     = err_q | memErrIn | load_reg_err;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    memEn     = 1'b0;
    memWr     = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    stall     = 1'b0;
    wbBubble  = 1'b0;
    loadData  = '0;

    unique case (state_q)
      IDLE: begin
        if (req_conflict) begin
          err_d = 1'b1;
        end else if (req_one) begin
          memEn     = 1'b1;
          memWr     = memWriteIn;
          memAddr   = addrIn;
          memWrData = wrDataIn;
          if (memDone) begin
            // Hit: data goes straight through, no stall, no state change.
            loadData = memRdData;
          end else begin
            state_d = BUSY;
            addr_d  = addrIn;
            wdata_d = wrDataIn;
            wr_d    = memWriteIn;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      BUSY: begin
        stall     = 1'b1;
        wbBubble  = 1'b1;
        memWr     = wr_q;
        memAddr   = addr_q;
        memWrData = wdata_q;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
        cnt_d     = cnt_q + 6'd1;
`endif
        if (memDone) begin
          state_d = RESP;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Give up on the request; memDone wins if it lands on the last cycle.
          err_d   = 1'b1;
          state_d = IDLE;
`endif
        end
      end

      RESP: begin
        // A request presented now is picked up by the following IDLE cycle.
        loadData = load_q;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Mask the flag during reset so it reads 0 before the clearing edge.
  assign err = err_q & ~rst;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed self-checking bench for mem_stage_ctrl. Inputs change just after
// each falling edge and outputs are sampled 1 ns later, well before the next
// rising edge. When MEM_STAGE_CTRL_TIMEOUT_EN is defined the DUT is built
// with TIMEOUT=8 and the timeout path is exercised; otherwise a long BUSY
// wait is exercised instead.
// ----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReadIn, memWriteIn;
  logic [15:0] addrIn, wrDataIn;
  logic        memDone;
  logic [15:0] memRdData;
  logic        memErrIn;
  logic        memEn, memWr;
  logic [15:0] memAddr, memWrData;
  logic        stall, wbBubble;
  logic [15:0] loadData;
  logic        err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int stallCycles = 0;
  int enPulses    = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .memReadIn  (memReadIn),
    .memWriteIn (memWriteIn),
    .addrIn     (addrIn),
    .wrDataIn   (wrDataIn),
    .memDone    (memDone),
    .memRdData  (memRdData),
    .memErrIn   (memErrIn),
    .memEn      (memEn),
    .memWr      (memWr),
    .memAddr    (memAddr),
    .memWrData  (memWrData),
    .stall      (stall),
    .wbBubble   (wbBubble),
    .loadData   (loadData),
    .err        (err)
  );

  // Drive one cycle's inputs after the falling edge, then let outputs settle.
  // Stall cycles and request strobes are tallied for per-transaction checks.
  task automatic applyStimulus(input logic r, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic done, input logic [15:0] rdata,
                               input logic merr);
    @(negedge clk);
    rst        = r;
    memReadIn  = rd;
    memWriteIn = wr;
    addrIn     = addr;
    wrDataIn   = wdata;
    memDone    = done;
    memRdData  = rdata;
    memErrIn   = merr;
    #1;
    if (stall) stallCycles++;
    if (memEn) enPulses++;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1; memReadIn = 0; memWriteIn = 0; addrIn = '0; wrDataIn = '0;
    memDone = 0; memRdData = '0; memErrIn = 0;

    // Reset
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("rst_err_low", 16'(err), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("rst_memEn", 16'(memEn), 16'h0);
    checkOutput("rst_stall", 16'(stall), 16'h0);
    checkOutput("rst_wbBubble", 16'(wbBubble), 16'h0);
    checkOutput("rst_loadData", loadData, 16'h0000);
    checkOutput("rst_memAddr", memAddr, 16'h0000);
    checkOutput("rst_err", 16'(err), 16'h0);

    // Hit: load completes in the issue cycle
    stallCycles = 0; enPulses = 0;
    applyStimulus(0, 1, 0, 16'h0040, 16'h0, 1, 16'hBEEF, 0);
    checkOutput("hit_memEn", 16'(memEn), 16'h1);
    checkOutput("hit_memWr", 16'(memWr), 16'h0);
    checkOutput("hit_memAddr", memAddr, 16'h0040);
    checkOutput("hit_loadData", loadData, 16'hBEEF);
    checkOutput("hit_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("hit_after_memEn", 16'(memEn), 16'h0);
    checkOutput("hit_after_loadData", loadData, 16'h0000);
    checkOutput("hit_stall_count", 16'(stallCycles), 16'd0);
    checkOutput("hit_en_count", 16'(enPulses), 16'd1);

    // Store miss: memDone four cycles after issue
    stallCycles = 0; enPulses = 0;
    applyStimulus(0, 0, 1, 16'h0100, 16'hCAFE, 0, 16'h0, 0);
    checkOutput("st_memEn", 16'(memEn), 16'h1);
    checkOutput("st_memWr", 16'(memWr), 16'h1);
    checkOutput("st_memAddr", memAddr, 16'h0100);
    checkOutput("st_memWrData", memWrData, 16'hCAFE);
    checkOutput("st_issue_stall", 16'(stall), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("st_b1_stall", 16'(stall), 16'h1);
    checkOutput("st_b1_wbBubble", 16'(wbBubble), 16'h1);
    checkOutput("st_b1_memEn", 16'(memEn), 16'h0);
    checkOutput("st_b1_memAddr", memAddr, 16'h0100);
    checkOutput("st_b1_memWrData", memWrData, 16'hCAFE);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 16'h0, 0);
    checkOutput("st_b4_stall", 16'(stall), 16'h1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("st_resp_stall", 16'(stall), 16'h0);
    checkOutput("st_resp_wbBubble", 16'(wbBubble), 16'h0);
    checkOutput("st_resp_memEn", 16'(memEn), 16'h0);
    checkOutput("st_stall_count", 16'(stallCycles), 16'd4);
    checkOutput("st_en_count", 16'(enPulses), 16'd1);

    // Load miss followed by an immediate load presented during RESP
    applyStimulus(0, 1, 0, 16'h0200, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("ld_b1_stall", 16'(stall), 16'h1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 16'h1234, 0);
    applyStimulus(0, 1, 0, 16'h0300, 16'h0, 0, 16'h0, 0);
    checkOutput("ld_resp_loadData", loadData, 16'h1234);
    checkOutput("ld_resp_memEn", 16'(memEn), 16'h0);
    checkOutput("ld_resp_stall", 16'(stall), 16'h0);
    applyStimulus(0, 1, 0, 16'h0300, 16'h0, 1, 16'h5678, 0);
    checkOutput("ld_next_memEn", 16'(memEn), 16'h1);
    checkOutput("ld_next_memAddr", memAddr, 16'h0300);
    checkOutput("ld_next_loadData", loadData, 16'h5678);

    // Memory error while BUSY: flag sets, transaction still completes
    applyStimulus(0, 1, 0, 16'h0500, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 1);
    checkOutput("merr_before", 16'(err), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 16'hAAAA, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("merr_err", 16'(err), 16'h1);
    checkOutput("merr_resp_loadData", loadData, 16'hAAAA);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("merr_sticky", 16'(err), 16'h1);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("merr_rst_err", 16'(err), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("merr_cleared", 16'(err), 16'h0);

    // Conflict: read and write together
    applyStimulus(0, 1, 1, 16'h0600, 16'h1111, 0, 16'h0, 0);
    checkOutput("cf_memEn", 16'(memEn), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("cf_err", 16'(err), 16'h1);
    checkOutput("cf_stall", 16'(stall), 16'h0);
    applyStimulus(0, 1, 0, 16'h0700, 16'h0, 1, 16'h4321, 0);
    checkOutput("cf_hit_memEn", 16'(memEn), 16'h1);
    checkOutput("cf_hit_loadData", loadData, 16'h4321);
    checkOutput("cf_err_sticky", 16'(err), 16'h1);

    // Reset in BUSY cycle 2, then a stray memDone
    applyStimulus(0, 1, 0, 16'h0800, 16'h0, 0, 16'h0, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("rb_b1_stall", 16'(stall), 16'h1);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("rb_rst_err", 16'(err), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("rb_stall", 16'(stall), 16'h0);
    checkOutput("rb_wbBubble", 16'(wbBubble), 16'h0);
    checkOutput("rb_memEn", 16'(memEn), 16'h0);
    checkOutput("rb_memAddr", memAddr, 16'h0000);
    checkOutput("rb_loadData", loadData, 16'h0000);
    checkOutput("rb_err", 16'(err), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 16'h9999, 0);
    checkOutput("rb_late_loadData", loadData, 16'h0000);
    checkOutput("rb_late_memEn", 16'(memEn), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("rb_late_next_stall", 16'(stall), 16'h0);
    checkOutput("rb_late_next_loadData", loadData, 16'h0000);

`ifdef MEM_STAGE_CTRL_TIMEOUT_EN
    // Timeout: TIMEOUT=8, memDone never arrives
    stallCycles = 0;
    applyStimulus(0, 1, 0, 16'h0900, 16'h0, 0, 16'h0, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
      if (i == 8) begin
        checkOutput("to_b8_stall", 16'(stall), 16'h1);
        checkOutput("to_b8_err", 16'(err), 16'h0);
      end
    end
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("to_err", 16'(err), 16'h1);
    checkOutput("to_stall", 16'(stall), 16'h0);
    checkOutput("to_memEn", 16'(memEn), 16'h0);
    checkOutput("to_stall_count", 16'(stallCycles), 16'd8);
`else
    // No timeout: BUSY holds well past any timeout value
    applyStimulus(0, 1, 0, 16'h0900, 16'h0, 0, 16'h0, 0);
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    end
    checkOutput("nt_b40_stall", 16'(stall), 16'h1);
    checkOutput("nt_b40_err", 16'(err), 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 16'h5A5A, 0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0);
    checkOutput("nt_resp_loadData", loadData, 16'h5A5A);
    checkOutput("nt_resp_stall", 16'(stall), 16'h0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
